// File: rtl/adder_rr_scheduler.sv
// ============================================================================
// Module   : adder_rr_scheduler
// Brief    : Round-robin time-sharing of one WIDTH-bit adder between two
//            valid/ready requesters. Optional macro SATURATE_EN clamps the sum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_rr_scheduler #(
  parameter int WIDTH   = 8,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic             busy
);

  localparam int            c_CW       = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(ADD_LAT - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [c_CW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic             last_grant_q;
  logic             rsp_valid_q, rsp_id_q, rsp_carry_q;
  logic [WIDTH-1:0] rsp_sum_q;

  logic             w_grant;
  logic             w_idle_en;
  logic             w_accept;
  logic             w_capture;
  logic             w_release;
  logic [WIDTH:0]   w_full;
  logic [WIDTH-1:0] w_sum;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~last_grant_q;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_idle_en = ena && (state_q == c_IDLE);
  assign w_accept  = w_idle_en && (req0_valid || req1_valid);
  assign w_capture = ena && (state_q == c_BUSY) && (cnt_q == '0);
  assign w_release = ena && (state_q == c_DONE) && rsp_valid_q && rsp_ready;

  assign w_full = {1'b0, a_q} + {1'b0, b_q};
`ifdef SATURATE_EN
  assign w_sum = w_full[WIDTH] ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
`else
  assign w_sum = w_full[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_accept)  state_d = c_BUSY;
      c_BUSY:  if (w_capture) state_d = c_DONE;
      c_DONE:  if (w_release) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = w_idle_en && req0_valid && !w_grant;
    req1_ready = w_idle_en && req1_valid &&  w_grant;
    busy       = (state_q != c_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      if (w_accept) begin
        a_q          <= w_grant ? req1_a : req0_a;
        b_q          <= w_grant ? req1_b : req0_b;
        id_q         <= w_grant;
        last_grant_q <= w_grant;
        cnt_q        <= c_CNT_INIT;
      end else if (ena && (state_q == c_BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - c_CW'(1);
      end
      if (w_capture) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_sum_q   <= w_sum;
        rsp_carry_q <= w_full[WIDTH];
      end else if (w_release) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;

endmodule

`default_nettype wire

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
Time-shares one WIDTH-bit adder between two requesters using round-robin arbitration and valid/ready handshakes.
- Each accepted operation is held stable on the adder for ADD_LAT cycles.
- The registered sum/carry is then returned on a single response channel, tagged with the requester id.
- Sits between the pin-mapping top level (ui_in/uio_in operand sources, uo_out result sink) and the adder datapath.

Parameters:
WIDTH, 8, operand/sum width in bits
ADD_LAT, 1, cycles operands are held on the adder before capture; legal 1..8

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes the block
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 handshake accepted this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 handshake accepted this cycle
req1_a  input  WIDTH  requester 1 operand A
req1_b  input  WIDTH  requester 1 operand B
rsp_valid  output  1  response registers hold a result
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester that issued the result
rsp_sum  output  WIDTH  result
rsp_carry  output  1  carry-out of A+B
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - State=IDLE; rsp_valid/rsp_id/rsp_sum/rsp_carry = 0; both ready = 0; busy = 0.
  - Latched operands and counter = 0; last_grant = 1, so requester 0 wins the first tie.
  - Reset mid-operation drops the in-flight op with no response.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Grant is combinational. Only one valid → that one. Both valid → the requester != last_grant.
  - reqN_ready = ena && IDLE && grant==N. At most one ready high at a time.
  - Handshake (valid&&ready at edge) latches a, b, id; sets last_grant=id, cnt=ADD_LAT-1; moves to BUSY.
- BUSY:
  - Latched operands drive the adder. cnt decrements each cycle.
  - At the edge where cnt==0: capture sum and carry (WIDTH+1-bit add) into the rsp registers, set rsp_valid=1, move to DONE.
  - The rsp_valid rising edge occurs exactly ADD_LAT edges after the accepting edge.
- DONE:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_valid&&rsp_ready: clear rsp_valid, go to IDLE. A new request cannot be accepted in the same cycle.
  - Minimum issue interval is ADD_LAT+2 cycles.
- Requests are never accepted outside IDLE; requester valid must be held until its ready.
- ena low:
  - Both ready forced 0; no state, counter or register changes; outputs hold their values.
  - rsp_ready is ignored while ena is low.
- Arithmetic: unsigned. Without the optional feature, rsp_sum = (A+B) mod 2^WIDTH and rsp_carry = bit WIDTH of the sum.
- The rsp_id/last_grant pointer updates only on request handshake, not on response.

Optional Feature:
Macro SATURATE_EN.
- Defined: when carry=1, rsp_sum = all-ones (2^WIDTH-1); rsp_carry still reports 1.
- Undefined: wrap-around sum as above.
- Latency and handshakes are identical in both builds.

Test Plan:
- Single ops, req0 only, ADD_LAT=1, rsp_ready=1:
  - 0x01+0x01 → sum 0x02, carry 0
  - 0x0F+0x01 → sum 0x10, carry 0
  - 0xAA+0x55 → sum 0xFF, carry 0
  - rsp_id=0 each time; rsp_valid exactly 1 edge after accept.
- Overflow: 0xFF+0x01 → sum 0x00, carry 1; with SATURATE_EN → sum 0xFF, carry 1.
- Arbitration:
  - Both valid out of reset, req0=(0x01,0x02), req1=(0x10,0x20) → first rsp id0 sum 0x03, then id1 sum 0x30.
  - Keep both valid → grants alternate 0,1,0,1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_sum/id/carry stable, both ready stay 0, busy=1; rsp_ready=1 → IDLE next cycle.
- ADD_LAT=4, ena toggle: accept 0x0F+0x0F.
  - ena low 3 cycles during BUSY → rsp_valid delayed by exactly 3 cycles; sum 0x1E.
  - Ready stays low throughout.
- Reset mid-BUSY: assert rst_n=0 asynchronously between edges → outputs 0 immediately.
  - After release, no stale response appears.
  - Next tie is granted to req0.
